pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and interlock controller for the 5-stage pipeline. It tracks the destination-register tags of instructions in the EX, MEM and WB stages, and from them drives three things:
- per-operand forwarding selects for the ID-stage `qa`/`qb` operands;
- a one-cycle load-use stall, which holds the PC and the IF/ID register;
- a bubble, which zeroes the control word entering ID/EX.

It sits beside the ID stage, between decode/regfile and the ID/EX register, and takes a branch/jump flush from the PC-select logic.

## Interface
Parameters:
- `NREG_W`, default 5: register-number width.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `id_rs`  in  NREG_W  ID source register A number.
- `id_rt`  in  NREG_W  ID source register B number.
- `id_use_rs`  in  1  ID instruction reads rs.
- `id_use_rt`  in  1  ID instruction reads rt.
- `id_wreg`  in  1  ID instruction writes the regfile.
- `id_m2reg`  in  1  ID instruction is a load.
- `id_wn`  in  NREG_W  ID destination register.
- `flush`  in  1  discard the instruction currently in ID (taken branch/jump).
- `stall`  out  1  hold PC and IF/ID this cycle.
- `bubble`  out  1  ID/EX latches `wreg=m2reg=wmem=0` this cycle.
- `fwda`  out  2  operand A source select.
- `fwdb`  out  2  operand B source select.
- `stall_cnt`  out  32  load-use stall counter; present only with `HAZ_STALL_CNT_EN`.

## Operation
Internal shadow tags. Each stage holds `{wreg, m2reg, wn}`:
- `EX` is loaded from the ID inputs, or with all zeros when `bubble=1`.
- `MEM` is loaded from `EX`.
- `WB` is loaded from `MEM`.

Forward select, shown for A (B is identical with `rt`/`use_rt`):
- `fwda=0` when `id_use_rs=0` or `id_rs==0`.
- Otherwise the priority is:
  - `1`: EX ALU result, when `EX.wreg && EX.wn==id_rs && !EX.m2reg`.
  - `2`: MEM result (ALU or load data), when `MEM.wreg && MEM.wn==id_rs`.
  - `3`: WB data, when `WB.wreg && WB.wn==id_rs`.
  - `0`: regfile, in all other cases.
- The youngest producer always wins.

Load-use:
- `lu = EX.wreg & EX.m2reg & ((id_use_rs & id_rs!=0 & EX.wn==id_rs) | (id_use_rt & id_rt!=0 & EX.wn==id_rt))`.
- `stall = lu & !flush`.
- `bubble = lu | flush`.
- When `lu` is set, `fwda`/`fwdb` for the matching operand are don't-care. They are driven 0.

Flush and stall together: flush wins. `stall=0` and `bubble=1`, because the ID instruction is discarded anyway.

A stalled instruction re-evaluates next cycle. By then the load has moved to MEM, so the select becomes `2` and no further stall occurs. A load-use stall is therefore always exactly one cycle.

Writes to register 0 never create a hazard and never forward.

## Timing
- `stall`, `bubble`, `fwda`, `fwdb` are combinational from the ID inputs and the shadow tags, with zero latency. They are valid before the same edge that latches IF/ID and ID/EX.
- Shadow tags update at each rising edge, one stage per cycle. MEM and WB advance even when `stall=1`.
- Reset values when `clr=1` at the edge:
  - all shadow tags are 0;
  - consequently `stall=0`, `bubble=0` (when `flush=0`), `fwda=fwdb=0`;
  - `stall_cnt=0`.
- Asserting `clr` mid-stall: the stall is abandoned next cycle and the tags clear. The ID inputs present in the reset cycle are not captured.
- `clr` has priority over every other input.

## Configuration
- `HAZ_STALL_CNT_EN` defined:
  - `stall_cnt` port exists;
  - it increments by 1 at each edge where `stall=1`;
  - it saturates at `32'hFFFF_FFFF` and clears on `clr`.
- `HAZ_STALL_CNT_EN` undefined: the port and counter are absent. Hazard behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - forward-select constants `FWD_RF=2'd0`, `FWD_EX=2'd1`, `FWD_MEM=2'd2`, `FWD_WB=2'd3`;
  - the stage-tag typedef `{wreg, m2reg, wn}`.
- Sub-module `pipe_stage_tag`: one tag register with synchronous `clr` and a load-zero (`kill`) input. It is instantiated three times: EX, MEM, WB.
- Forward-select compare logic is written once as a function and used for both operands.

## Test plan
- Reset: hold `clr=1` for 2 cycles with arbitrary inputs. Required: `stall=0`, `bubble=0`, `fwda=fwdb=0`, `stall_cnt=0`.
- ALU back-to-back: cycle n ID `wreg=1, wn=5`; cycle n+1 ID `rs=5, use_rs=1`. Required: `fwda=1`, `stall=0`. At n+2 with the same rs: `fwda=2`. At n+3: `fwda=3`. At n+4: `fwda=0`.
- Load-use: cycle n ID `m2reg=1, wreg=1, wn=7`; cycle n+1 ID `rt=7, use_rt=1`. Required:
  - cycle n+1: `stall=1`, `bubble=1`;
  - cycle n+2: `stall=0`, `fwdb=2`;
  - `stall_cnt` increments by exactly 1.
- Register 0 and priority:
  - producer with `wn=0` followed by a consumer with `rs=0` gives `fwda=0`;
  - EX and MEM both writing r3, consumer `rs=3` gives `fwda=1`.
- Flush during load-use: the load-use setup from the load-use scenario, with `flush=1` at n+1. Required: `stall=0`, `bubble=1`, `stall_cnt` unchanged, EX tag zero at n+2.
- Counter saturation (`HAZ_STALL_CNT_EN`): force the counter to `32'hFFFF_FFFF`, then trigger a stall. Required: counter stays `32'hFFFF_FFFF`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select codes and the per-stage destination tag.
package pipe_pkg;

    localparam int unsigned TAG_WN_W = 8;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic                wreg;
        logic                m2reg;
        logic [TAG_WN_W-1:0] wn;
    } stage_tag_t;

endpackage

// File: rtl/pipe_stage_tag.sv
// One shadow destination-tag register with synchronous clear and a load-zero kill.
module pipe_stage_tag
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       kill,
    input  stage_tag_t d,
    output stage_tag_t q
);

    always_ff @(posedge clk) begin
        if (clr || kill) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/interlock controller: operand forwarding, one-cycle load-use stall, bubble insertion.
// Optional load-use stall counter port enabled by defining HAZ_STALL_CNT_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned NREG_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [NREG_W-1:0] id_wn,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    if (NREG_W > TAG_WN_W) begin : g_width_check
        $error("NREG_W exceeds the tag register-number width");
    end

    stage_tag_t id_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;
    logic       lu_a;
    logic       lu_b;
    logic       lu;

    // Load in EX feeding this operand: value not available yet, must stall.
    function automatic logic load_hit(input logic [NREG_W-1:0] r, input logic use_r,
                                      input stage_tag_t ex);
        logic [TAG_WN_W-1:0] rx;
        rx = TAG_WN_W'(r);
        return use_r && (r != '0) && ex.wreg && ex.m2reg && (ex.wn == rx);
    endfunction

    // Youngest matching producer wins; a matching load in EX yields regfile (stall covers it).
    function automatic logic [1:0] fwd_sel(input logic [NREG_W-1:0] r, input logic use_r,
                                           input stage_tag_t ex, input stage_tag_t mem,
                                           input stage_tag_t wb);
        logic [TAG_WN_W-1:0] rx;
        logic [1:0]          sel;
        rx  = TAG_WN_W'(r);
        sel = FWD_RF;
        if (use_r && (r != '0)) begin
            if (ex.wreg && (ex.wn == rx)) begin
                sel = ex.m2reg ? FWD_RF : FWD_EX;
            end else if (mem.wreg && (mem.wn == rx)) begin
                sel = FWD_MEM;
            end else if (wb.wreg && (wb.wn == rx)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        id_tag       = '0;
        id_tag.wreg  = id_wreg;
        id_tag.m2reg = id_m2reg;
        id_tag.wn    = TAG_WN_W'(id_wn);
    end

    always_comb begin
        lu_a   = load_hit(id_rs, id_use_rs, ex_tag);
        lu_b   = load_hit(id_rt, id_use_rt, ex_tag);
        lu     = lu_a || lu_b;
        stall  = lu && !flush;
        bubble = lu || flush;
        fwda   = fwd_sel(id_rs, id_use_rs, ex_tag, mem_tag, wb_tag);
        fwdb   = fwd_sel(id_rt, id_use_rt, ex_tag, mem_tag, wb_tag);
    end

    pipe_stage_tag u_ex (
        .clk  (clk),
        .clr  (clr),
        .kill (bubble),
        .d    (id_tag),
        .q    (ex_tag)
    );

    pipe_stage_tag u_mem (
        .clk  (clk),
        .clr  (clr),
        .kill (1'b0),
        .d    (ex_tag),
        .q    (mem_tag)
    );

    pipe_stage_tag u_wb (
        .clk  (clk),
        .clr  (clr),
        .kill (1'b0),
        .d    (mem_tag),
        .q    (wb_tag)
    );

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] cnt_q;

    // Saturating count of cycles spent in load-use stall.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (counter checks when HAZ_STALL_CNT_EN is defined).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic       id_m2reg;
    logic [4:0] id_wn;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [1:0] fwda;
    logic [1:0] fwdb;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] cnt_before;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREG_W(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .id_wn     (id_wn),
        .flush     (flush),
        .stall     (stall),
        .bubble    (bubble),
        .fwda      (fwda),
        .fwdb      (fwdb)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply ID-stage inputs, then let combinational outputs settle.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic w, input logic m,
                         input logic [4:0] wn, input logic fl);
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = w;
        id_m2reg  = m;
        id_wn     = wn;
        flush     = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push three empty instructions so all shadow tags drain to zero.
    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) step();
    endtask

    initial begin
        clr = 1'b1;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
        step();
        step();

        // Reset: reset-cycle producer r5 must not have been captured.
        clr = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bubble", 32'(bubble), 32'd0);
        check("rst_fwda", 32'(fwda), 32'd0);
        check("rst_fwdb", 32'(fwdb), 32'd0);
`ifdef HAZ_STALL_CNT_EN
        check("rst_cnt", stall_cnt, 32'd0);
`endif
        idle();

        // ALU back-to-back on r5: select walks EX -> MEM -> WB -> regfile.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
        step();
        drive(5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check("alu_fwda_ex", 32'(fwda), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_fwdb_unused", 32'(fwdb), 32'd0);
        step();
        check("alu_fwda_mem", 32'(fwda), 32'd2);
        step();
        check("alu_fwda_wb", 32'(fwda), 32'd3);
        step();
        check("alu_fwda_rf", 32'(fwda), 32'd0);
        idle();

        // Load-use on rt=r7: one stall cycle, then MEM forward.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_bubble", 32'(bubble), 32'd1);
        check("lu_fwdb_dc", 32'(fwdb), 32'd0);
`ifdef HAZ_STALL_CNT_EN
        cnt_before = stall_cnt;
`endif
        step();
        check("lu2_stall", 32'(stall), 32'd0);
        check("lu2_bubble", 32'(bubble), 32'd0);
        check("lu2_fwdb", 32'(fwdb), 32'd2);
`ifdef HAZ_STALL_CNT_EN
        check("lu_cnt_inc", stall_cnt, cnt_before + 32'd1);
`endif
        idle();

        // Register 0 never forwards.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("r0_fwda", 32'(fwda), 32'd0);
        check("r0_stall", 32'(stall), 32'd0);
        idle();

        // Priority: r3 in EX and MEM -> EX; r3 in MEM and WB -> MEM.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
        step();
        step();
        drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("prio_ex_a", 32'(fwda), 32'd1);
        check("prio_ex_b", 32'(fwdb), 32'd1);
        step();
        check("prio_mem_a", 32'(fwda), 32'd2);
        drive(5'd3, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("use_rs_off", 32'(fwda), 32'd0);
        idle();

        // Flush during load-use: flush wins, EX receives a bubble (r9 producer dropped).
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1);
        check("fl_stall", 32'(stall), 32'd0);
        check("fl_bubble", 32'(bubble), 32'd1);
`ifdef HAZ_STALL_CNT_EN
        cnt_before = stall_cnt;
`endif
        step();
        drive(5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("fl_ex_zero", 32'(fwda), 32'd0);
        check("fl_load_mem", 32'(fwdb), 32'd2);
`ifdef HAZ_STALL_CNT_EN
        check("fl_cnt_same", stall_cnt, cnt_before);
`endif
        idle();

        // Reset mid-stall abandons the stall and clears tags.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
        check("clr_pre_stall", 32'(stall), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        drive(5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        check("clr_stall", 32'(stall), 32'd0);
        check("clr_fwda", 32'(fwda), 32'd0);
        check("clr_fwdb", 32'(fwdb), 32'd0);
        idle();

`ifdef HAZ_STALL_CNT_EN
        // Saturation: counter pinned at all-ones survives another stall.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        step();
        drive(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        check("sat_stall", 32'(stall), 32'd1);
        step();
        check("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
